// File: rtl/lcd1602_byte_sequencer.sv
// lcd1602_byte_sequencer: expands one LCD byte into a PCF8574 address byte plus four 4-bit-mode expander bytes, then waits the LCD execution time.
module lcd1602_byte_sequencer #(
  parameter logic [7:0] SLAVE_ADDR = 8'h4E,
  parameter logic       BACKLIGHT  = 1'b1,
  parameter int         WAIT_SHORT = 2000,
  parameter int         WAIT_LONG  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] lcd_data,
  output logic       ready,
  output logic       done,
  output logic       en_write,
  output logic [7:0] data,
  input  logic       write_done,
  output logic       frame_active
);
  localparam int CW = WAIT_LONG > 0 ? $clog2(WAIT_LONG + 1) : 1;
  localparam logic [CW-1:0] SHORT_N = CW'(WAIT_SHORT);
  localparam logic [CW-1:0] LONG_N = CW'(WAIT_LONG);
  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT, FIN} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic rs_q, rs_d;
  logic [7:0] lcd_q, lcd_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d, wait_n;
  logic [3:0] nib;
  assign nib = idx_q < 3'd3 ? lcd_q[7:4] : lcd_q[3:0];
  assign wait_n = (!rs_q && lcd_q[7:2] == 6'd0) ? LONG_N : SHORT_N;
  assign ready = state_q == IDLE;
  assign en_write = state_q == SEND;
  assign frame_active = state_q == SEND || state_q == GAP;
  assign done = state_q == FIN;
  assign data = data_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rs_d = rs_q;
    lcd_d = lcd_q;
    data_d = data_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = SEND;
        idx_d = 3'd0;
        rs_d = rs;
        lcd_d = lcd_data;
        data_d = SLAVE_ADDR;
      end
      SEND: if (write_done) begin
        if (idx_q == 3'd4) begin
          state_d = wait_n == '0 ? FIN : WAIT;
          cnt_d = wait_n;
        end else begin
          state_d = GAP;
          idx_d = idx_q + 3'd1;
        end
      end
      GAP: begin
        state_d = SEND;
        data_d = {nib, BACKLIGHT, idx_q[0], 1'b0, rs_q};
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? FIN : WAIT;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 3'd0;
      rs_q <= 1'b0;
      lcd_q <= 8'h00;
      data_q <= 8'h00;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rs_q <= rs_d;
      lcd_q <= lcd_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_lcd1602_byte_sequencer.sv
// tb_lcd1602_byte_sequencer: directed frames against a BACKLIGHT=1 and a BACKLIGHT=0 instance sharing all inputs.
module tb_lcd1602_byte_sequencer;
  localparam int NS = 5;
  localparam int NL = 50;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, rs = 1'b0, write_done = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic ready, done, en_write, frame_active;
  logic [7:0] data;
  logic ready0, done0, en_write0, frame_active0;
  logic [7:0] data0;
  int checks = 0, errors = 0;
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  lcd1602_byte_sequencer #(.SLAVE_ADDR(8'h4E), .BACKLIGHT(1'b1), .WAIT_SHORT(NS), .WAIT_LONG(NL)) dut (
    .clk(clk), .rst(rst), .req(req), .rs(rs), .lcd_data(lcd_data), .ready(ready), .done(done),
    .en_write(en_write), .data(data), .write_done(write_done), .frame_active(frame_active));
  lcd1602_byte_sequencer #(.SLAVE_ADDR(8'h4E), .BACKLIGHT(1'b0), .WAIT_SHORT(NS), .WAIT_LONG(NL)) dut0 (
    .clk(clk), .rst(rst), .req(req), .rs(rs), .lcd_data(lcd_data), .ready(ready0), .done(done0),
    .en_write(en_write0), .data(data0), .write_done(write_done), .frame_active(frame_active0));
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // e1/e0 hold the four expander bytes (MSB first) for BACKLIGHT=1 and BACKLIGHT=0
  task automatic frame(input logic r, input logic [7:0] d, input logic [31:0] e1, input logic [31:0] e0,
                       input int n, input int lat, input logic stray, input logic busy, input logic coinc,
                       input int abort);
    logic [15:0] exp;
    logic ok;
    int k;
    chk("ready_before", ready, 1);
    sb.push_back({8'h4E, 8'h4E});
    for (int i = 3; i >= 0; i--) sb.push_back({e1[8*i+:8], e0[8*i+:8]});
    req = 1'b1;
    rs = r;
    lcd_data = d;
    write_done = coinc;
    tick;
    req = 1'b0;
    write_done = 1'b0;
    for (int b = 0; b < 5; b++) begin
      if (b == abort) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_en", en_write, 0);
        chk("rst_fa", frame_active, 0);
        chk("rst_ready", ready, 1);
        chk("rst_data", data, 0);
        ok = 1'b1;
        repeat (20) begin
          tick;
          ok = ok && !done && !en_write && ready;
        end
        chk("rst_quiet", ok, 1);
        sb.delete();
        lcd_data = 8'h00;
        rs = 1'b0;
        return;
      end
      exp = sb.pop_front();
      chk("en_rise", en_write, 1);
      chk("byte", data, exp[15:8]);
      chk("byte_bl0", data0, exp[7:0]);
      chk("fa_send", frame_active, 1);
      ok = 1'b1;
      for (int s = 0; s < lat; s++) begin
        if (busy && b == 1 && s == 0) begin
          req = 1'b1;
          rs = !r;
          lcd_data = 8'hFF;
        end
        tick;
        req = 1'b0;
        ok = ok && en_write === 1'b1 && data === exp[15:8] && frame_active === 1'b1 && ready === 1'b0;
      end
      chk("stall_stable", ok, 1);
      write_done = 1'b1;
      tick;
      write_done = 1'b0;
      chk("en_fall", en_write, 0);
      if (b < 4) begin
        chk("gap_fa", frame_active, 1);
        write_done = stray;
        tick;
        write_done = 1'b0;
      end
    end
    chk("fa_fall", frame_active, 0);
    write_done = stray;
    k = 0;
    while (!done && k < n + 20) begin
      tick;
      write_done = 1'b0;
      k++;
    end
    chk("wait_len", k, n);
    chk("done_ready", ready, 0);
    tick;
    chk("done_pulse", done, 0);
    chk("ready_back", ready, 1);
    ok = 1'b1;
    repeat (5) begin
      tick;
      ok = ok && !en_write && !done && ready;
    end
    chk("idle_quiet", ok, 1);
    lcd_data = 8'h00;
    rs = 1'b0;
  endtask
  initial begin
    repeat (2) tick;
    rst = 1'b0;
    chk("reset_en", en_write, 0);
    chk("reset_data", data, 0);
    chk("reset_fa", frame_active, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", ready, 1);
    frame(1'b1, 8'h41, 32'h4D491D19, 32'h45411511, NS, 1, 1'b0, 1'b0, 1'b0, -1);
    frame(1'b0, 8'h01, 32'h0C081C18, 32'h04001410, NL, 1, 1'b0, 1'b0, 1'b1, -1);
    frame(1'b0, 8'h28, 32'h2C288C88, 32'h24208480, NS, 1, 1'b0, 1'b0, 1'b0, -1);
    frame(1'b1, 8'h80, 32'h8D890D09, 32'h85810501, NS, 300, 1'b1, 1'b0, 1'b0, -1);
    frame(1'b0, 8'h03, 32'h0C083C38, 32'h04003430, NL, 3, 1'b0, 1'b1, 1'b0, -1);
    frame(1'b1, 8'h41, 32'h4D491D19, 32'h45411511, NS, 2, 1'b0, 1'b0, 1'b0, 2);
    frame(1'b1, 8'h41, 32'h4D491D19, 32'h45411511, NS, 1, 1'b0, 1'b0, 1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
